// File: rtl/spi_master_xfer_ctrl.sv
// SPI mode-0, MSB-first transaction sequencer between a TX word FIFO and an RX word FIFO.
// Drives CSn/SCLK/SDO and freezes SCLK while the TX FIFO is empty or the RX holding register is full.
module spi_master_xfer_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic                  tx_en_i,
  input  logic                  rx_en_i,
  input  logic [DIV_WIDTH-1:0]  clkdiv_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  spi_clk_o,
  output logic                  spi_csn_o,
  output logic                  spi_sdo_o,
  input  logic                  spi_sdi_i,
  output logic [2:0]            dbg_state_o
);

  localparam int WB = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    LOAD     = 3'd2,
    SHIFT    = 3'd3,
    WAIT_RX  = 3'd4,
    CS_HOLD  = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  len_left_q;
  logic [DIV_WIDTH-1:0]  div_q, div_cnt_q;
  logic                  tx_en_q, rx_en_q, phase_q, done_q, rx_valid_q;
  logic [WB-1:0]         wbit_q;
  logic [DATA_WIDTH-1:0] tx_sh_q, rx_sh_q, rx_data_q;

  logic accept, zero_start, load_word, rise, bit_end, push, hold_done;
  logic div_tick, rx_free, last_bit, word_end, counting;

  // Both FIFO sides use valid/ready: a word moves on a cycle where valid and ready are both high;
  // valid never waits on ready, and a producer keeps valid and data stable until the transfer.
  assign div_tick = (div_cnt_q == div_q);
  assign rx_free  = !rx_valid_q || rx_ready_i;
  assign last_bit = (len_left_q == CNT_WIDTH'(1));
  assign word_end = (wbit_q == WB'(DATA_WIDTH - 1)) || last_bit;
  assign counting = (state_q == CS_SETUP) || (state_q == SHIFT) ||
                    ((state_q == CS_HOLD) && !rx_valid_q);

  always_comb begin
    state_d    = state_q;
    tx_ready_o = 1'b0;
    accept     = 1'b0;
    zero_start = 1'b0;
    load_word  = 1'b0;
    rise       = 1'b0;
    bit_end    = 1'b0;
    push       = 1'b0;
    hold_done  = 1'b0;
    case (state_q)
      IDLE: begin
        // done_q marks the completion cycle, in which a new start is still refused
        if (start_i && !done_q) begin
          if (len_i != '0) begin
            accept  = 1'b1;
            state_d = CS_SETUP;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      CS_SETUP: if (div_tick) state_d = LOAD;
      LOAD: begin
        if (!tx_en_q || tx_valid_i) begin
          tx_ready_o = tx_en_q;
          load_word  = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (div_tick) begin
          if (!phase_q) begin
            rise = 1'b1;
          end else begin
            bit_end = 1'b1;
            if (word_end) begin
              if (!rx_en_q || rx_free) begin
                push    = rx_en_q;
                state_d = last_bit ? CS_HOLD : LOAD;
              end else begin
                state_d = WAIT_RX;
              end
            end
          end
        end
      end
      WAIT_RX: begin
        if (rx_free) begin
          push    = 1'b1;
          state_d = (len_left_q == '0) ? CS_HOLD : LOAD;
        end
      end
      CS_HOLD: begin
        if (!rx_valid_q && div_tick) begin
          hold_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      len_left_q <= '0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b0;
      phase_q    <= 1'b0;
      done_q     <= 1'b0;
      wbit_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= zero_start | hold_done;
      div_cnt_q <= (counting && !div_tick) ? div_cnt_q + DIV_WIDTH'(1) : '0;
      if (accept) begin
        len_left_q <= len_i;
        div_q      <= clkdiv_i;
        tx_en_q    <= tx_en_i;
        rx_en_q    <= rx_en_i;
      end
      if (load_word) begin
        tx_sh_q <= tx_en_q ? tx_data_i : '0;
        rx_sh_q <= '0;
        wbit_q  <= '0;
        phase_q <= 1'b0;
      end else if ((state_q == SHIFT) && div_tick) begin
        phase_q <= ~phase_q;
      end
      // Shifting left from a cleared register leaves a partial final word right-aligned
      if (rise) rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], spi_sdi_i};
      if (bit_end) begin
        tx_sh_q    <= tx_sh_q << 1;
        len_left_q <= len_left_q - CNT_WIDTH'(1);
        wbit_q     <= wbit_q + WB'(1);
      end
      if (push) begin
        rx_data_q  <= rx_sh_q;
        rx_valid_q <= 1'b1;
      end else if (rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign busy_o      = (state_q != IDLE) || done_q;
  assign done_o      = done_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign spi_csn_o   = (state_q == IDLE);
  assign spi_clk_o   = (state_q == SHIFT) && phase_q;
  assign spi_sdo_o   = (state_q == SHIFT) && tx_sh_q[DATA_WIDTH-1];
  assign dbg_state_o = state_q;

endmodule
